// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate multiply-accumulate datapath.
package approx_mac_pkg;

    // Default widths of the multiplier product and of the accumulator.
    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;

    // Saturation limits for the default accumulator width.
    localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Accumulator control states.
    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } acc_state_e;

endpackage

// File: rtl/approx_dot_accumulator_sat_add.sv
// Combinational signed adder with one guard bit, overflow flag and optional clamp.
module sat_add #(
    parameter int W        = 40,
    parameter bit SATURATE = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    // Add with a guard bit; the guard and MSB disagree exactly on signed overflow.
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        ovf  = wide[W] ^ wide[W-1];
        sum  = wide[W-1:0];
        if (ovf && SATURATE) begin
            // The guard bit carries the true sign of the unbounded result.
            sum = wide[W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/approx_dot_accumulator.sv
// Streaming signed packet accumulator placed behind the approximate Booth multiplier.
// A packet of products (terminated by in_last) is summed and handed downstream
// together with its term count and a sticky overflow flag.
module approx_dot_accumulator
    import approx_mac_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    acc_state_e         state_q, state_d;
    logic               s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic               s1_last_q, s1_last_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_next;

    // A held final beat blocks intake until the packet has been closed.
    assign in_ready  = (state_q == ACCUM) && !(s1_valid_q && s1_last_q);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    assign prod_ext = {{(ACC_W-PROD_W){s1_prod_q[PROD_W-1]}}, s1_prod_q};
    assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    sat_add #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state logic: input capture, accumulation, packet close and result handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        s1_valid_d  = 1'b0;
        s1_prod_d   = s1_prod_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_valid && in_ready) begin
            s1_valid_d = 1'b1;
            s1_prod_d  = in_prod;
            s1_last_d  = in_last;
        end

        if (s1_valid_q) begin
            if (s1_last_q) begin
                state_d     = OUT;
                out_valid_d = 1'b1;
                out_sum_d   = add_sum;
                out_count_d = cnt_next;
                out_ovf_d   = ovf_q | add_ovf;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = add_sum;
                cnt_d = cnt_next;
                ovf_d = ovf_q | add_ovf;
            end
        end

        if ((state_q == OUT) && out_valid_q && out_ready) begin
            state_d     = ACCUM;
            out_valid_d = 1'b0;
        end
    end

    // Control and result registers; reset and clear both abandon all packet state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clear) begin
            state_q     <= ACCUM;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Stage-1 payload registers.
    always_ff @(posedge clk) begin
        // NOTE: payload flops are left unreset; s1_valid_q qualifies every use of them.
        s1_prod_q <= s1_prod_d;
        s1_last_q <= s1_last_d;
    end

endmodule
